// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predict unit: default widths, branch opcodes,
// 2-bit counter encodings and the saturating counter step.
package branch_predict_unit_pkg;

  localparam int PC_WIDTH_DEF  = 32;
  localparam int DWIDTH_DEF    = 32;
  localparam int IMM_WIDTH_DEF = 16;
  localparam int OPCODE_WIDTH  = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    BPU_CTR_SNT = 2'b00,
    BPU_CTR_WNT = 2'b01,
    BPU_CTR_WT  = 2'b10,
    BPU_CTR_ST  = 2'b11
  } bpu_ctr_e;

  // Step a 2-bit counter toward the resolved outcome, clamped at both ends.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == BPU_CTR_ST) nxt = ctr;
      else                   nxt = ctr + 2'b01;
    end else begin
      if (ctr == BPU_CTR_SNT) nxt = ctr;
      else                    nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_btb.sv
// bpu_btb: direct-mapped branch target buffer with a fetch read port, a decode
// read port (both combinational) and one synchronous write port.
module bpu_btb
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int TAG_W    = PC_WIDTH - IDX_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [PC_WIDTH-1:0] rd_target,
  output logic [1:0]          rd_ctr,
  input  logic [IDX_W-1:0]    upd_idx,
  output logic                upd_valid,
  output logic [TAG_W-1:0]    upd_tag,
  output logic [1:0]          upd_ctr,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [1:0]          wr_ctr,
  input  logic                wr_target_en,
  input  logic [PC_WIDTH-1:0] wr_target
);

  logic                valid_r  [DEPTH];
  logic [TAG_W-1:0]    tag_r    [DEPTH];
  logic [PC_WIDTH-1:0] target_r [DEPTH];
  logic [1:0]          ctr_r    [DEPTH];

  // No write-to-read bypass: both read ports see the pre-edge contents.
  assign rd_valid  = valid_r[rd_idx];
  assign rd_tag    = tag_r[rd_idx];
  assign rd_target = target_r[rd_idx];
  assign rd_ctr    = ctr_r[rd_idx];

  assign upd_valid = valid_r[upd_idx];
  assign upd_tag   = tag_r[upd_idx];
  assign upd_ctr   = ctr_r[upd_idx];

  // Entry storage: reset clears every entry, otherwise a single-entry write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {PC_WIDTH{1'b0}};
        ctr_r[i]    <= BPU_CTR_WNT;
      end
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
      tag_r[wr_idx]   <= wr_tag;
      ctr_r[wr_idx]   <= wr_ctr;
      if (wr_target_en) target_r[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB lookup for fetch, BEQ/BNE resolution in decode and the
// redirect/flush mux. Optional perf counters are built with BPU_PERF_EN.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int IMM_WIDTH = IMM_WIDTH_DEF,
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int TAG_W     = PC_WIDTH - IDX_W - 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PC_WIDTH-1:0]     i_if_pc,
  output logic                    o_pred_taken,
  output logic [PC_WIDTH-1:0]     o_pred_target,
  input  logic                    i_id_valid,
  input  logic                    i_stall,
  input  logic                    i_branch,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [PC_WIDTH-1:0]     i_id_pc,
  input  logic [IMM_WIDTH-1:0]    i_imm,
  input  logic [DWIDTH-1:0]       i_data_r1,
  input  logic [DWIDTH-1:0]       i_data_r2,
  input  logic                    i_id_pred_taken,
  input  logic [PC_WIDTH-1:0]     i_id_pred_target,
  input  logic                    i_es_change_pc,
  input  logic [PC_WIDTH-1:0]     i_es_pc,
  output logic                    o_change_pc,
  output logic [PC_WIDTH-1:0]     o_pc,
  output logic                    o_flush
`ifdef BPU_PERF_EN
  ,
  output logic [31:0]             o_br_count,
  output logic [31:0]             o_mispred_count
`endif
);

  logic [IDX_W-1:0]    if_idx_s;
  logic [TAG_W-1:0]    if_tag_s;
  logic [IDX_W-1:0]    id_idx_s;
  logic [TAG_W-1:0]    id_tag_s;
  logic                rd_valid_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic [PC_WIDTH-1:0] rd_target_s;
  logic [1:0]          rd_ctr_s;
  logic                upd_valid_s;
  logic [TAG_W-1:0]    upd_tag_s;
  logic [1:0]          upd_ctr_s;
  logic                if_hit_s;
  logic                upd_hit_s;
  logic [PC_WIDTH-1:0] imm_sext_s;
  logic [PC_WIDTH-1:0] fall_s;
  logic [PC_WIDTH-1:0] tgt_s;
  logic                taken_s;
  logic                mispred_s;
  logic                update_s;
  logic                wr_en_s;
  logic [1:0]          wr_ctr_s;
  logic [1:0]          pc_unused_s;

  // Fetch PCs are word aligned; the byte-offset bits carry no index or tag.
  assign pc_unused_s = i_if_pc[1:0];

  assign if_idx_s = i_if_pc[IDX_W+1:2];
  assign if_tag_s = i_if_pc[PC_WIDTH-1:IDX_W+2];
  assign id_idx_s = i_id_pc[IDX_W+1:2];
  assign id_tag_s = i_id_pc[PC_WIDTH-1:IDX_W+2];

  assign if_hit_s  = rd_valid_s && (rd_tag_s == if_tag_s);
  assign upd_hit_s = upd_valid_s && (upd_tag_s == id_tag_s);

  // Fetch-side prediction straight from the table contents.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = {PC_WIDTH{1'b0}};
    if (if_hit_s) begin
      o_pred_taken  = rd_ctr_s[1];
      o_pred_target = rd_target_s;
    end else begin
      o_pred_taken  = 1'b0;
      o_pred_target = {PC_WIDTH{1'b0}};
    end
  end

  assign imm_sext_s = {{(PC_WIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
  assign fall_s     = i_id_pc + {{(PC_WIDTH-3){1'b0}}, 3'b100};
  assign tgt_s      = fall_s + (imm_sext_s << 2);

  // Branch outcome; opcodes other than BEQ/BNE resolve not-taken.
  always_comb begin
    taken_s = 1'b0;
    case (i_opcode)
      OP_BEQ:  taken_s = (i_data_r1 == i_data_r2);
      OP_BNE:  taken_s = (i_data_r1 != i_data_r2);
      default: taken_s = 1'b0;
    endcase
  end

  assign mispred_s = i_id_valid && i_branch &&
                     ((taken_s != i_id_pred_taken) ||
                      (taken_s && (i_id_pred_target != tgt_s)));

  // Redirect mux: an execute-stage redirect outranks the decode resolution.
  always_comb begin
    o_change_pc = 1'b0;
    o_pc        = {PC_WIDTH{1'b0}};
    o_flush     = 1'b0;
    if (i_es_change_pc) begin
      o_change_pc = 1'b1;
      o_pc        = i_es_pc;
      o_flush     = 1'b1;
    end else if (mispred_s) begin
      o_change_pc = 1'b1;
      o_pc        = taken_s ? tgt_s : fall_s;
      o_flush     = 1'b1;
    end else begin
      o_change_pc = 1'b0;
      o_pc        = {PC_WIDTH{1'b0}};
      o_flush     = 1'b0;
    end
  end

  assign update_s = i_id_valid && i_branch && !i_stall && !i_es_change_pc;

  // Table write: train a hitting entry, allocate only on a taken miss.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_ctr_s = BPU_CTR_WT;
    if (update_s && upd_hit_s) begin
      wr_en_s  = 1'b1;
      wr_ctr_s = ctr_next(upd_ctr_s, taken_s);
    end else if (update_s && taken_s) begin
      wr_en_s  = 1'b1;
      wr_ctr_s = BPU_CTR_WT;
    end else begin
      wr_en_s  = 1'b0;
      wr_ctr_s = BPU_CTR_WT;
    end
  end

  bpu_btb #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_btb (
    .clk          (i_clk),
    .rst          (i_rst),
    .rd_idx       (if_idx_s),
    .rd_valid     (rd_valid_s),
    .rd_tag       (rd_tag_s),
    .rd_target    (rd_target_s),
    .rd_ctr       (rd_ctr_s),
    .upd_idx      (id_idx_s),
    .upd_valid    (upd_valid_s),
    .upd_tag      (upd_tag_s),
    .upd_ctr      (upd_ctr_s),
    .wr_en        (wr_en_s),
    .wr_idx       (id_idx_s),
    .wr_tag       (id_tag_s),
    .wr_ctr       (wr_ctr_s),
    .wr_target_en (taken_s),
    .wr_target    (tgt_s)
  );

`ifdef BPU_PERF_EN
  logic [31:0] br_count_r;
  logic [31:0] mispred_count_r;

  // Perf counters share the table-update qualification and wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_count_r      <= 32'd0;
      mispred_count_r <= 32'd0;
    end else if (update_s) begin
      br_count_r <= br_count_r + 32'd1;
      if (mispred_s) mispred_count_r <= mispred_count_r + 32'd1;
    end
  end

  assign o_br_count      = br_count_r;
  assign o_mispred_count = mispred_count_r;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit with hand-computed
// expectations (default parameters: 32-bit PC, DEPTH=16).
module tb_branch_predict_unit;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ADD = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid, stall, branch;
  logic [5:0]  opcode;
  logic [31:0] id_pc;
  logic [15:0] imm;
  logic [31:0] r1, r2;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        es_change;
  logic [31:0] es_pc;
  logic        change_pc;
  logic [31:0] pc;
  logic        flush;
`ifdef BPU_PERF_EN
  logic [31:0] br_count, mispred_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_unit dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_id_valid       (id_valid),
    .i_stall          (stall),
    .i_branch         (branch),
    .i_opcode         (opcode),
    .i_id_pc          (id_pc),
    .i_imm            (imm),
    .i_data_r1        (r1),
    .i_data_r2        (r2),
    .i_id_pred_taken  (id_pred_taken),
    .i_id_pred_target (id_pred_target),
    .i_es_change_pc   (es_change),
    .i_es_pc          (es_pc),
    .o_change_pc      (change_pc),
    .o_pc             (pc),
    .o_flush          (flush)
`ifdef BPU_PERF_EN
    ,
    .o_br_count       (br_count),
    .o_mispred_count  (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        id_valid, stall, branch;
    logic [5:0]  opcode;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [31:0] r1, r2;
    logic        pt;
    logic [31:0] ptg;
    logic        es;
    logic [31:0] esp;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_ch;
    logic [31:0] e_pc;
    logic        e_fl;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic [31:0] ifp, input logic v, input logic s, input logic b,
    input logic [5:0] op, input logic [31:0] idp, input logic [15:0] im,
    input logic [31:0] a, input logic [31:0] c, input logic pt, input logic [31:0] ptg,
    input logic es, input logic [31:0] esp,
    input logic e_pt, input logic [31:0] e_ptg, input logic e_ch, input logic [31:0] e_pc,
    input logic e_fl);
    vec_t t;
    t.if_pc = ifp; t.id_valid = v; t.stall = s; t.branch = b; t.opcode = op;
    t.id_pc = idp; t.imm = im; t.r1 = a; t.r2 = c; t.pt = pt; t.ptg = ptg;
    t.es = es; t.esp = esp; t.e_pt = e_pt; t.e_ptg = e_ptg; t.e_ch = e_ch;
    t.e_pc = e_pc; t.e_fl = e_fl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    if_pc = t.if_pc; id_valid = t.id_valid; stall = t.stall; branch = t.branch;
    opcode = t.opcode; id_pc = t.id_pc; imm = t.imm; r1 = t.r1; r2 = t.r2;
    id_pred_taken = t.pt; id_pred_target = t.ptg; es_change = t.es; es_pc = t.esp;
  endtask

  task automatic idle(input logic [31:0] lookup);
    drive(mk(lookup, 1'b0, 1'b0, 1'b0, ADD, 32'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    check({tag, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, t.e_pt});
    check({tag, ".pred_target"}, pred_target, t.e_ptg);
    check({tag, ".change_pc"},   {31'd0, change_pc}, {31'd0, t.e_ch});
    check({tag, ".pc"},          pc, t.e_pc);
    check({tag, ".flush"},       {31'd0, flush}, {31'd0, t.e_fl});
  endtask

  // Apply inputs just after a rising edge, sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    //          if_pc      v     s     b     op   id_pc      imm       r1     r2     pt    ptg        es    esp          e_pt  e_ptg      e_ch  e_pc       e_fl
    vecs[0]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd5, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h54,  1'b1);
    vecs[1]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd6, 1'b1, 32'h54,  1'b0, 32'h0,   1'b1, 32'h54, 1'b1, 32'h44,  1'b1);
    vecs[2]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd6, 1'b0, 32'h54,  1'b0, 32'h0,   1'b0, 32'h54, 1'b0, 32'h0,   1'b0);
    vecs[3]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd5, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h54, 1'b1, 32'h54,  1'b1);
    vecs[4]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd5, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h54, 1'b1, 32'h54,  1'b1);
    vecs[5]  = mk(32'h40,  1'b0, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd5, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h54, 1'b0, 32'h0,   1'b0);
    vecs[6]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BNE, 32'h40,  16'h0004, 32'd1, 32'd2, 1'b1, 32'h54,  1'b0, 32'h0,   1'b1, 32'h54, 1'b0, 32'h0,   1'b0);
    vecs[7]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BNE, 32'h40,  16'h0004, 32'd1, 32'd2, 1'b1, 32'h54,  1'b0, 32'h0,   1'b1, 32'h54, 1'b0, 32'h0,   1'b0);
    vecs[8]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BNE, 32'h40,  16'h0004, 32'd3, 32'd3, 1'b1, 32'h54,  1'b0, 32'h0,   1'b1, 32'h54, 1'b1, 32'h44,  1'b1);
    vecs[9]  = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd6, 1'b1, 32'h54,  1'b1, 32'h200, 1'b1, 32'h54, 1'b1, 32'h200, 1'b1);
    vecs[10] = mk(32'h40,  1'b1, 1'b0, 1'b1, BEQ, 32'h40,  16'h0004, 32'd5, 32'd5, 1'b1, 32'h60,  1'b0, 32'h0,   1'b1, 32'h54, 1'b1, 32'h54,  1'b1);
    vecs[11] = mk(32'h104, 1'b1, 1'b0, 1'b1, BEQ, 32'h104, 16'hFFFE, 32'd7, 32'd7, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h100, 1'b1);
    vecs[12] = mk(32'h104, 1'b1, 1'b0, 1'b1, BEQ, 32'h80,  16'h0008, 32'd7, 32'd7, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100,1'b1, 32'hA4,  1'b1);
    vecs[13] = mk(32'h40,  1'b0, 1'b0, 1'b0, BEQ, 32'h0,   16'h0000, 32'd0, 32'd0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0);
    vecs[14] = mk(32'h80,  1'b1, 1'b0, 1'b1, ADD, 32'h80,  16'h0000, 32'd9, 32'd9, 1'b1, 32'h84,  1'b0, 32'h0,   1'b1, 32'hA4, 1'b1, 32'h84,  1'b1);
    vecs[15] = mk(32'h80,  1'b0, 1'b0, 1'b0, ADD, 32'h0,   16'h0000, 32'd0, 32'd0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'hA4, 1'b0, 32'h0,   1'b0);

    rst = 1'b1;
    idle(32'h40);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset.pred_taken",  {31'd0, pred_taken}, 32'd0);
    check("reset.pred_target", pred_target, 32'h0);
    check("reset.change_pc",   {31'd0, change_pc}, 32'd0);
`ifdef BPU_PERF_EN
    check("reset.br_count",      br_count, 32'd0);
    check("reset.mispred_count", mispred_count, 32'd0);
`endif
    next_cycle();
    rst = 1'b0;

    // Table: allocation, counter training, saturation, es priority, alias.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i]);
      next_cycle();
    end

    // Reset while an update-qualified taken branch sits in decode.
    drive(mk(32'h80, 1'b1, 1'b0, 1'b1, BEQ, 32'h80, 16'h0008, 32'd1, 32'd1, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    idle(32'h80);
    @(negedge clk);
    check("midrst.pred_taken",  {31'd0, pred_taken}, 32'd0);
    check("midrst.pred_target", pred_target, 32'h0);
`ifdef BPU_PERF_EN
    check("midrst.br_count", br_count, 32'd0);
`endif
    next_cycle();

    // Stall held three cycles on a taken branch: only the release cycle updates.
    t = mk(32'h308, 1'b1, 1'b1, 1'b1, BEQ, 32'h308, 16'h0001, 32'd4, 32'd4, 1'b0, 32'h0,
           1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h310, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(t);
      @(negedge clk);
      check($sformatf("stall%0d", c), {31'd0, change_pc}, 32'd1);
      check($sformatf("stall%0d.pc", c), pc, 32'h310);
      check($sformatf("stall%0d.pred", c), {31'd0, pred_taken}, 32'd0);
      next_cycle();
    end
    t.stall = 1'b0;
    drive(t);
    @(negedge clk);
    check_outs("release", t);
    next_cycle();
    idle(32'h308);
    @(negedge clk);
    check("after_stall.pred_taken",  {31'd0, pred_taken}, 32'd1);
    check("after_stall.pred_target", pred_target, 32'h310);
`ifdef BPU_PERF_EN
    check("after_stall.br_count",      br_count, 32'd1);
    check("after_stall.mispred_count", mispred_count, 32'd1);
`endif
    next_cycle();

    // One not-taken outcome: a single prior update leaves ctr 10 -> 01.
    t = mk(32'h308, 1'b1, 1'b0, 1'b1, BEQ, 32'h308, 16'h0001, 32'd4, 32'd5, 1'b1, 32'h310,
           1'b0, 32'h0, 1'b1, 32'h310, 1'b1, 32'h30C, 1'b1);
    drive(t);
    @(negedge clk);
    check_outs("nt_after_stall", t);
    next_cycle();
    idle(32'h308);
    @(negedge clk);
    check("single_update.pred_taken",  {31'd0, pred_taken}, 32'd0);
    check("single_update.pred_target", pred_target, 32'h310);
`ifdef BPU_PERF_EN
    check("final.br_count",      br_count, 32'd2);
    check("final.mispred_count", mispred_count, 32'd2);
`endif
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the decode-stage branch/hazard resolver. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can redirect on predicted-taken branches. BEQ/BNE are still resolved in decode against the carried prediction. It sits between IF (lookup) and ID (resolve/update) and drives the pipeline PC-redirect/flush; an execute-stage redirect keeps priority.

## Interface
Parameters:
- PC_WIDTH, default `PC_WIDTH: PC width.
- DWIDTH, default `DWIDTH: register data width.
- IMM_WIDTH, default `IMM_WIDTH: branch immediate width.
- DEPTH, default 16: BTB entries; power of two, ≥2.
- IDX_W, default $clog2(DEPTH): index bits, taken from pc[IDX_W+1:2].
- TAG_W, default PC_WIDTH-IDX_W-2: tag bits, taken from pc[PC_WIDTH-1:IDX_W+2].

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_if_pc  in  PC_WIDTH  fetch PC for lookup.
- o_pred_taken  out  1  fetch prediction.
- o_pred_target  out  PC_WIDTH  predicted target.
- i_id_valid  in  1  decode slot holds a real instruction.
- i_stall  in  1  decode stalled this cycle.
- i_branch  in  1  decode instruction is a conditional branch.
- i_opcode  in  `OPCODE_WIDTH  decode opcode (`BEQ/`BNE).
- i_id_pc  in  PC_WIDTH  PC of the decode instruction.
- i_imm  in  IMM_WIDTH  branch immediate (word offset).
- i_data_r1, i_data_r2  in  DWIDTH  forwarded operands.
- i_id_pred_taken  in  1  prediction carried with the instruction.
- i_id_pred_target  in  PC_WIDTH  predicted target carried with the instruction.
- i_es_change_pc  in  1  execute-stage redirect (jump/jr).
- i_es_pc  in  PC_WIDTH  execute-stage target.
- o_change_pc  out  1  redirect fetch this cycle.
- o_pc  out  PC_WIDTH  redirect target.
- o_flush  out  1  kill the IF/ID wrong-path instruction.
- o_br_count, o_mispred_count  out  32  perf counters (only with BPU_PERF_EN).

## Operation
- Entry contents: valid, tag, target[PC_WIDTH], ctr[1:0].
- Lookup (combinational from registered arrays):
  - hit = valid[idx] && tag match.
  - o_pred_taken = hit && ctr[1].
  - o_pred_target = target[idx] when hit, else 0.
- Resolve (combinational):
  - fall = i_id_pc+4.
  - tgt = i_id_pc+4+(sext(i_imm)<<2).
  - taken = (BEQ && r1==r2) || (BNE && r1!=r2); any other opcode gives taken=0.
- Mispredict = i_id_valid && i_branch && (taken != i_id_pred_taken || (taken && i_id_pred_target != tgt)).
  - Redirect goes to tgt when taken, else fall.
- Priority:
  - i_es_change_pc=1: o_change_pc=1, o_pc=i_es_pc, o_flush=1. Decode resolution is suppressed (wrong path) and the table is not updated.
  - Otherwise a mispredict gives o_change_pc=1, o_flush=1 with the target above.
  - Otherwise all three outputs are 0.
- Update on the clock edge when i_id_valid && i_branch && !i_stall && !i_es_change_pc:
  - Decode-index hit: ctr saturating +1 if taken, −1 if not (clamped at 00/11). Target is rewritten with tgt when taken.
  - Miss and taken: allocate valid=1, tag, target=tgt, ctr=10 (replaces any entry).
  - Miss and not taken: no change.
- Stalled decode never updates, so one branch updates at most once.

## Timing
- Redirect outputs are combinational, same cycle as decode.
- Table writes become visible to lookup the cycle after the update edge. There is no write-to-read bypass: a same-cycle lookup of the updated index sees the old entry.
- Reset (any cycle, including mid-update):
  - All valid=0, all ctr=01, targets=0.
  - Perf counters 0.
  - Outputs follow the inputs: with valid=0, o_pred_taken=0 and o_pred_target=0.
- Counters wrap modulo 2^32.

## Configuration
- BPU_PERF_EN defined:
  - o_br_count increments on every update-qualified branch.
  - o_mispred_count increments when that branch also mispredicts.
  - Both share the update qualification.
- BPU_PERF_EN undefined: the ports and registers are absent; no other behaviour changes.

## Structure
- `BPU_CTR_SNT/WNT/WT/ST (00..11) go in header.vh, alongside the existing opcode and width constants.
- One sub-module, bpu_btb: DEPTH-entry storage with a combinational read port and one synchronous write port, plus its own sync reset of valid/ctr.
- Compare/redirect logic and the perf counters stay in the top.

## Test plan
- Reset, then lookup pc=0x40 → o_pred_taken=0. BEQ at 0x40, imm=4, r1=r2=5, pred 0 → o_change_pc=1, o_pc=0x54, o_flush=1. Next cycle lookup 0x40 → taken, target 0x54.
- Same branch not-taken twice after allocation → ctr 10→01→00. A third lookup predicts not-taken. Two more taken outcomes take ctr 00→01→10 and the prediction turns taken.
- Correct prediction: BNE, r1≠r2, pred_taken=1, pred_target=tgt → o_change_pc=0, o_flush=0; ctr saturates at 11.
- i_es_change_pc=1 with i_es_pc=0x200 while decode would mispredict → o_pc=0x200; the BTB entry is unchanged next cycle.
- i_stall=1 held 3 cycles on a taken branch → exactly one update. With BPU_PERF_EN, o_br_count=1 and o_mispred_count=1.
- Alias: a branch at 0x40 and one at 0x40+4·DEPTH share an index → the second allocates and the tag replaces the first. The first then misses: o_pred_taken=0.
